// File: rtl/vga_box_renderer_if.sv
// Timing bus from the VGA sync/timing generator into the pixel stage.
// The generator (master) drives all signals; the renderer (slave) only reads.
interface vga_box_renderer_if;
  // Bus contract: there is no valid/ready handshake. One pixel slot per
  // clock, always accepted. in_vid_on marks a visible pixel slot.
  // row/col run one cycle ahead of in_hsync/in_vsync/in_vid_on, so the
  // consumer registers row/col once to line them up with the flags.
  logic        in_hsync;
  logic        in_vsync;
  logic        in_vid_on;
  logic [10:0] row;
  logic [10:0] col;

  modport master (
    output in_hsync,
    output in_vsync,
    output in_vid_on,
    output row,
    output col
  );

  modport slave (
    input in_hsync,
    input in_vsync,
    input in_vid_on,
    input row,
    input col
  );
endinterface

// File: rtl/vga_box_renderer.sv
// vga_box_renderer: pixel stage after the VGA timing generator.
// Draws a solid box over a background colour; the box bounces diagonally
// off the display edges, moving once per frame during vertical blanking.
// Optional macro VGA_BOX_BORDER_EN paints a white 1-pixel frame around the
// visible area, taking priority over box and background.
module vga_box_renderer #(
  parameter int          HDISP     = 640,
  parameter int          VDISP     = 480,
  parameter int          BOX_W     = 32,
  parameter int          BOX_H     = 32,
  parameter int          SPEED     = 2,
  parameter int          X0        = 100,
  parameter int          Y0        = 80,
  parameter logic [11:0] BG_COLOR  = 12'h008,
  parameter logic [11:0] BOX_COLOR = 12'hFF0
) (
  input  logic                clk25,
  input  logic                rst,
  vga_box_renderer_if.slave   tim,
  input  logic                run,
  output logic                hsync,
  output logic                vsync,
  output logic [11:0]         rgb,
  output logic [15:0]         frame_cnt,
  output logic [1:0]          dbg_state,
  output logic [10:0]         dbg_box_x,
  output logic [10:0]         dbg_box_y,
  output logic                dbg_dir_x,
  output logic                dbg_dir_y
);

  // Motion FSM encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] UPD_X = 2'd1;
  localparam logic [1:0] UPD_Y = 2'd2;

  // Direction encoding: forward = right (x) / down (y)
  localparam logic DIR_FWD  = 1'b0;
  localparam logic DIR_BACK = 1'b1;

  // 12-bit constants so box position + size + speed never wraps
  localparam logic [11:0] BOX_W12 = 12'(BOX_W);
  localparam logic [11:0] BOX_H12 = 12'(BOX_H);
  localparam logic [11:0] SPD12   = 12'(SPEED);
  localparam logic [11:0] HDISP12 = 12'(HDISP);
  localparam logic [11:0] VDISP12 = 12'(VDISP);

  localparam logic [10:0] SPD11   = 11'(SPEED);
  localparam logic [10:0] X_MAX   = 11'(HDISP - BOX_W);
  localparam logic [10:0] Y_MAX   = 11'(VDISP - BOX_H);
  localparam logic [10:0] X_RST   = 11'(X0);
  localparam logic [10:0] Y_RST   = 11'(Y0);

`ifdef VGA_BOX_BORDER_EN
  localparam logic [10:0] COL_LAST = 11'(HDISP - 1);
  localparam logic [10:0] ROW_LAST = 11'(VDISP - 1);
`endif

  logic [10:0] row_d;
  logic [10:0] col_d;
  logic        vsync_d;
  logic        fedge;
  logic [1:0]  state;
  logic [10:0] box_x;
  logic [10:0] box_y;
  logic        dir_x;
  logic        dir_y;

  logic [11:0] col_e;
  logic [11:0] row_e;
  logic [11:0] box_x_e;
  logic [11:0] box_y_e;
  logic        in_box;
  logic [11:0] pix;
  logic        hit_right;
  logic        hit_left;
  logic        hit_bottom;
  logic        hit_top;

  // Stage A: delay row/col one cycle so they line up with the in_* flags
  always_ff @(posedge clk25 or negedge rst) begin
    if (!rst) begin
      row_d <= '0;
      col_d <= '0;
    end else begin
      row_d <= tim.row;
      col_d <= tim.col;
    end
  end

  // Hit test and colour selection for the aligned pixel
  always_comb begin
    col_e   = {1'b0, col_d};
    row_e   = {1'b0, row_d};
    box_x_e = {1'b0, box_x};
    box_y_e = {1'b0, box_y};
    in_box  = (col_e >= box_x_e) && (col_e < box_x_e + BOX_W12) &&
              (row_e >= box_y_e) && (row_e < box_y_e + BOX_H12);
    pix     = in_box ? BOX_COLOR : BG_COLOR;
`ifdef VGA_BOX_BORDER_EN
    if ((col_d == 11'd0) || (col_d == COL_LAST) ||
        (row_d == 11'd0) || (row_d == ROW_LAST)) begin
      pix = 12'hFFF;
    end
`endif
  end

  // Stage B: register sync and colour to the pins, blanking outside video
  always_ff @(posedge clk25 or negedge rst) begin
    if (!rst) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      rgb   <= '0;
    end else begin
      hsync <= tim.in_hsync;
      vsync <= tim.in_vsync;
      rgb   <= tim.in_vid_on ? pix : 12'h000;
    end
  end

  // Falling edge of vsync marks the start of a new frame
  assign fedge = vsync_d & ~tim.in_vsync;

  // Remember previous vsync and count completed frames
  always_ff @(posedge clk25 or negedge rst) begin
    if (!rst) begin
      vsync_d   <= 1'b1;
      frame_cnt <= '0;
    end else begin
      vsync_d <= tim.in_vsync;
      if (fedge) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  // Edge conditions for the bounce decisions
  always_comb begin
    hit_right  = (box_x_e + BOX_W12 + SPD12) >= HDISP12;
    hit_left   = box_x <= SPD11;
    hit_bottom = (box_y_e + BOX_H12 + SPD12) >= VDISP12;
    hit_top    = box_y <= SPD11;
  end

  // Motion FSM: one axis per cycle right after the vsync falling edge.
  // vsync falls during vertical blanking, so the visible frame always sees
  // a stable box position without shadow registers.
  always_ff @(posedge clk25 or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      box_x <= X_RST;
      box_y <= Y_RST;
      dir_x <= DIR_FWD;
      dir_y <= DIR_FWD;
    end else begin
      case (state)
        IDLE: begin
          if (fedge && run) begin
            state <= UPD_X;
          end
        end
        UPD_X: begin
          if (dir_x == DIR_FWD) begin
            if (hit_right) begin
              box_x <= X_MAX;
              dir_x <= DIR_BACK;
            end else begin
              box_x <= box_x + SPD11;
            end
          end else begin
            if (hit_left) begin
              box_x <= 11'd0;
              dir_x <= DIR_FWD;
            end else begin
              box_x <= box_x - SPD11;
            end
          end
          state <= UPD_Y;
        end
        UPD_Y: begin
          if (dir_y == DIR_FWD) begin
            if (hit_bottom) begin
              box_y <= Y_MAX;
              dir_y <= DIR_BACK;
            end else begin
              box_y <= box_y + SPD11;
            end
          end else begin
            if (hit_top) begin
              box_y <= 11'd0;
              dir_y <= DIR_FWD;
            end else begin
              box_y <= box_y - SPD11;
            end
          end
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Observability of internal state
  assign dbg_state = state;
  assign dbg_box_x = box_x;
  assign dbg_box_y = box_y;
  assign dbg_dir_x = dir_x;
  assign dbg_dir_y = dir_y;

endmodule

// File: tb/tb_vga_box_renderer.sv
// Testbench for vga_box_renderer: directed pixel/frame steps with a
// scoreboard of expected rgb/hsync/vsync, plus a second instance started
// near the right edge to exercise the bounce.
module tb_vga_box_renderer;

  logic        clk25;
  logic        rst;
  logic        run;
  logic        hsync, vsync;
  logic [11:0] rgb;
  logic [15:0] frame_cnt;
  logic [1:0]  dbg_state;
  logic [10:0] dbg_box_x, dbg_box_y;
  logic        dbg_dir_x, dbg_dir_y;

  logic        b_hsync, b_vsync;
  logic [11:0] b_rgb;
  logic [15:0] b_frame_cnt;
  logic [1:0]  b_state;
  logic [10:0] b_box_x, b_box_y;
  logic        b_dir_x, b_dir_y;

  vga_box_renderer_if bus ();

  vga_box_renderer u_dut (
    .clk25(clk25), .rst(rst), .tim(bus.slave), .run(run),
    .hsync(hsync), .vsync(vsync), .rgb(rgb), .frame_cnt(frame_cnt),
    .dbg_state(dbg_state), .dbg_box_x(dbg_box_x), .dbg_box_y(dbg_box_y),
    .dbg_dir_x(dbg_dir_x), .dbg_dir_y(dbg_dir_y)
  );

  vga_box_renderer #(.X0(607)) u_bounce (
    .clk25(clk25), .rst(rst), .tim(bus.slave), .run(run),
    .hsync(b_hsync), .vsync(b_vsync), .rgb(b_rgb), .frame_cnt(b_frame_cnt),
    .dbg_state(b_state), .dbg_box_x(b_box_x), .dbg_box_y(b_box_y),
    .dbg_dir_x(b_dir_x), .dbg_dir_y(b_dir_y)
  );

  // Clock and watchdog
  initial begin
    clk25 = 1'b0;
    forever #20 clk25 = ~clk25;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard state
  int n_tests = 0;
  int n_fail  = 0;
  logic [13:0] exp_q[$];

  // Bench-side flag pipeline (flags lag row/col by one slot)
  bit p_vid = 1'b0;
  bit p_hs  = 1'b1;
  bit p_vs  = 1'b1;

  // Reference model of the main instance's box
  int m_bx = 100;
  int m_by = 80;
  bit m_left = 1'b0;
  bit m_up   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] exp_pix(input int r, input int c, input bit vid);
    if (!vid) return 12'h000;
`ifdef VGA_BOX_BORDER_EN
    if (c == 0 || c == 639 || r == 0 || r == 479) return 12'hFFF;
`endif
    if (c >= m_bx && c < m_bx + 32 && r >= m_by && r < m_by + 32) return 12'hFF0;
    return 12'h008;
  endfunction

  task automatic model_move();
    if (!m_left) begin
      if (m_bx + 32 + 2 >= 640) begin m_bx = 608; m_left = 1'b1; end
      else m_bx = m_bx + 2;
    end else begin
      if (m_bx <= 2) begin m_bx = 0; m_left = 1'b0; end
      else m_bx = m_bx - 2;
    end
    if (!m_up) begin
      if (m_by + 32 + 2 >= 480) begin m_by = 448; m_up = 1'b1; end
      else m_by = m_by + 2;
    end else begin
      if (m_by <= 2) begin m_by = 0; m_up = 1'b0; end
      else m_by = m_by - 2;
    end
  endtask

  // Driver: one pixel slot. Pushes the expectation for this slot, then
  // checks the slot driven one step earlier against the pins.
  // fixed_rgb >= 0 supplies a literal expected colour instead of the model.
  task automatic step(input int r, input int c, input bit vid, input bit hs,
                      input bit vs, input int fixed_rgb = -1);
    logic [13:0] e;
    logic [11:0] er;
    bus.row       = 11'(r);
    bus.col       = 11'(c);
    bus.in_vid_on = p_vid;
    bus.in_hsync  = p_hs;
    bus.in_vsync  = p_vs;
    if (p_vs && !vs && run) model_move();
    er = (fixed_rgb >= 0) ? 12'(fixed_rgb) : exp_pix(r, c, vid);
    exp_q.push_back({er, hs, vs});
    p_vid = vid;
    p_hs  = hs;
    p_vs  = vs;
    @(posedge clk25);
    #1;
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      chk("rgb",   {20'd0, rgb},   {20'd0, e[13:2]});
      chk("hsync", {31'd0, hsync}, {31'd0, e[1]});
      chk("vsync", {31'd0, vsync}, {31'd0, e[0]});
    end
  endtask

  // One vertical blanking interval with a vsync pulse
  task automatic frame();
    step(480, 0, 1'b0, 1'b1, 1'b1);
    repeat (3) step(490, 0, 1'b0, 1'b1, 1'b0);
    repeat (4) step(495, 0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic flush();
    repeat (2) step(0, 0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    rst = 1'b0;
    run = 1'b0;
    bus.row = '0; bus.col = '0;
    bus.in_vid_on = 1'b0; bus.in_hsync = 1'b1; bus.in_vsync = 1'b1;
    repeat (3) @(posedge clk25);
    #1;
    rst = 1'b1;

    // Put some activity on the pins, then reset mid-line
    step(80, 110, 1'b1, 1'b0, 1'b1);
    step(80, 111, 1'b1, 1'b0, 1'b1);
    step(80, 112, 1'b1, 1'b0, 1'b1);
    #10;
    rst = 1'b0;
    #1;
    chk("rst_hsync", {31'd0, hsync}, 32'd1);
    chk("rst_vsync", {31'd0, vsync}, 32'd1);
    chk("rst_rgb", {20'd0, rgb}, 32'd0);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    chk("rst_box_x", {21'd0, dbg_box_x}, 32'd100);
    chk("rst_box_y", {21'd0, dbg_box_y}, 32'd80);
    chk("rst_b_box_x", {21'd0, b_box_x}, 32'd607);
    exp_q.delete();
    p_vid = 1'b0; p_hs = 1'b1; p_vs = 1'b1;
    @(posedge clk25);
    #1;
    rst = 1'b1;

    // First visible pixel after reset release
`ifdef VGA_BOX_BORDER_EN
    step(0, 0, 1'b1, 1'b1, 1'b1, 12'hFFF);
`else
    step(0, 0, 1'b1, 1'b1, 1'b1, 12'h008);
`endif
    step(0, 1, 1'b0, 1'b1, 1'b1);

    // Box hit around the left edge of the box, toggling hsync
    step(80, 99,  1'b1, 1'b0, 1'b1, 12'h008);
    step(80, 100, 1'b1, 1'b1, 1'b1, 12'hFF0);
    step(80, 131, 1'b1, 1'b0, 1'b1, 12'hFF0);
    step(80, 132, 1'b1, 1'b1, 1'b1, 12'h008);
    step(111, 131, 1'b1, 1'b0, 1'b1, 12'hFF0);
    step(112, 131, 1'b1, 1'b1, 1'b1, 12'h008);
    step(81, 120, 1'b0, 1'b1, 1'b1, 12'h000);
    flush();

    // Motion: three frames with run=1
    run = 1'b1;
    frame();
    chk("b_box_x_f1", {21'd0, b_box_x}, 32'd608);
    chk("b_dir_x_f1", {31'd0, b_dir_x}, 32'd1);
    frame();
    chk("b_box_x_f2", {21'd0, b_box_x}, 32'd606);
    frame();
    chk("box_x_f3", {21'd0, dbg_box_x}, 32'd106);
    chk("box_y_f3", {21'd0, dbg_box_y}, 32'd86);
    chk("frame_cnt_f3", {16'd0, frame_cnt}, 32'd3);
    chk("state_idle_f3", {30'd0, dbg_state}, 32'd0);
    step(86, 105, 1'b1, 1'b1, 1'b1, 12'h008);
    step(86, 106, 1'b1, 1'b1, 1'b1, 12'hFF0);
    step(117, 137, 1'b1, 1'b1, 1'b1);
    step(118, 137, 1'b1, 1'b1, 1'b1);
    flush();

    // Freeze for five frames, then resume
    run = 1'b0;
    repeat (5) frame();
    chk("freeze_box_x", {21'd0, dbg_box_x}, 32'd106);
    chk("freeze_box_y", {21'd0, dbg_box_y}, 32'd86);
    chk("freeze_frame_cnt", {16'd0, frame_cnt}, 32'd8);
    run = 1'b1;
    frame();
    chk("resume_box_x", {21'd0, dbg_box_x}, 32'd108);
    chk("resume_box_y", {21'd0, dbg_box_y}, 32'd88);
    chk("resume_frame_cnt", {16'd0, frame_cnt}, 32'd9);
    step(88, 108, 1'b1, 1'b1, 1'b1, 12'hFF0);
    step(88, 107, 1'b1, 1'b1, 1'b1, 12'h008);

    // Display-edge pixels
`ifdef VGA_BOX_BORDER_EN
    step(200, 0,   1'b1, 1'b1, 1'b1, 12'hFFF);
    step(200, 639, 1'b1, 1'b1, 1'b1, 12'hFFF);
    step(0,   300, 1'b1, 1'b1, 1'b1, 12'hFFF);
    step(479, 300, 1'b1, 1'b1, 1'b1, 12'hFFF);
`else
    step(200, 0,   1'b1, 1'b1, 1'b1, 12'h008);
    step(200, 639, 1'b1, 1'b1, 1'b1, 12'h008);
    step(0,   300, 1'b1, 1'b1, 1'b1, 12'h008);
    step(479, 300, 1'b1, 1'b1, 1'b1, 12'h008);
`endif
    step(201, 1, 1'b1, 1'b1, 1'b1, 12'h008);
    flush();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_box_renderer.md
Name: vga_box_renderer

Overview:
- Pixel-generation stage directly downstream of the VGA sync/timing generator, in the 25 MHz pixel domain.
- Consumes the timing generator's hsync/vsync/vid_on and row/col, and outputs 12-bit RGB plus delayed sync to the VGA pins.
- Draws a solid box on a background colour. The box moves diagonally and bounces off the display edges, with its position updated once per frame during vertical blanking.

Parameters:
- HDISP, 640, visible columns
- VDISP, 480, visible rows
- BOX_W, 32, box width in pixels (1..HDISP)
- BOX_H, 32, box height in pixels (1..VDISP)
- SPEED, 2, pixels moved per frame on each axis (1..31)
- X0, 100, reset column of box top-left
- Y0, 80, reset row of box top-left
- BG_COLOR, 12'h008, background RGB 4:4:4
- BOX_COLOR, 12'hFF0, box RGB 4:4:4

Ports:
- clk25  in  1  pixel clock, 25 MHz
- rst  in  1  asynchronous reset, active-low (asserted when 0)
- in_hsync  in  1  registered hsync from the timing generator
- in_vsync  in  1  registered vsync from the timing generator, active-low pulse
- in_vid_on  in  1  registered visible-area flag
- row  in  11  current row count; one cycle ahead of in_* flags
- col  in  11  current column count; one cycle ahead of in_* flags
- run  in  1  1 = box moves each frame; 0 = box position frozen
- hsync  out  1  in_hsync delayed 1 cycle
- vsync  out  1  in_vsync delayed 1 cycle
- rgb  out  12  pixel colour, aligned with hsync/vsync
- frame_cnt  out  16  count of completed frames (vsync falling edges), wraps

Behaviour:
- Reset values (rst=0, asynchronous): hsync=1, vsync=1, rgb=0, frame_cnt=0, box_x=X0, box_y=Y0, dir_x=right, dir_y=down, FSM=IDLE, vsync_d=1.
- Pipeline stage A: register row/col into row_d/col_d, which aligns them with the in_* flags.
- Pipeline stage B:
  - hsync<=in_hsync, vsync<=in_vsync.
  - rgb<=0 when in_vid_on=0.
  - Otherwise rgb<=BOX_COLOR if box_x<=col_d<box_x+BOX_W and box_y<=row_d<box_y+BOX_H, else BG_COLOR.
- Latency: output = in_* delayed 1 cycle; rgb reflects the row/col presented 2 cycles earlier.
- Hit-test arithmetic uses 12-bit sums so box_x+BOX_W cannot overflow.
- Frame edge: vsync_d registers in_vsync. fedge = vsync_d & ~in_vsync (falling edge). Each fedge increments frame_cnt mod 2^16.
- Motion FSM:
  - IDLE: on fedge, go to UPD_X if run=1; stay in IDLE if run=0. frame_cnt increments in either case.
  - UPD_X, one cycle:
    - dir right and box_x+BOX_W+SPEED>=HDISP: box_x<=HDISP-BOX_W, dir_x<=left.
    - dir right otherwise: box_x+=SPEED.
    - dir left and box_x<=SPEED: box_x<=0, dir_x<=right.
    - dir left otherwise: box_x-=SPEED.
    - Then go to UPD_Y.
  - UPD_Y: same rules as UPD_X using box_y, BOX_H, VDISP and dir_y (down/up). Then go to IDLE.
- Updates occur only in vertical blanking (vsync falls after row VDISP-1), so a frame never shows a partially moved box; no shadow registers are needed.
- A second fedge arriving while in UPD_X/UPD_Y cannot happen (frames are far longer than 2 cycles). If it does, it is ignored apart from the frame_cnt increment.
- Changing run mid-frame takes effect at the next fedge.
- Reset mid-frame: all state returns to reset values immediately. The first fedge after release performs a normal update.

Optional Feature:
- Macro: VGA_BOX_BORDER_EN.
- Defined: when in_vid_on=1 and col_d==0, col_d==HDISP-1, row_d==0 or row_d==VDISP-1, rgb<=12'hFFF. This overrides box and background; the box still never overlaps the border logic's priority.
- Undefined: no border logic is compiled in, and edge pixels follow normal box/background rules.

Test Plan:
- Reset: assert rst=0 mid-line -> immediately hsync=1, vsync=1, rgb=0, frame_cnt=0. After release, first visible pixel (0,0) gives rgb=12'h008 two cycles after row/col=0,0.
- Box hit: defaults, drive row=80 with col=99,100,131,132 -> rgb = 008, FF0, FF0, 008 respectively. Check 2-cycle latency; hsync/vsync delayed exactly 1 cycle.
- Motion: run=1, three vsync falling edges -> box_x=106, box_y=86, frame_cnt=3. Pixel (106,86)=FF0, pixel (105,86)=008.
- Right bounce: start box_x=607 heading right (BOX_W=32) -> one frame gives box_x=608 and dir left; next frame gives box_x=606.
- Freeze: run=0 across 5 frames -> box_x, box_y unchanged and frame_cnt advances by 5. run=1 -> movement resumes on the next edge.
- Border (VGA_BOX_BORDER_EN defined): pixels (0,200), (639,200), (300,0), (300,479) -> rgb=FFF. Same pixels with the macro undefined -> 008.
